// File: rtl/reg8_bank_sequencer.sv
// reg8_bank_sequencer: single-command sequencer driving an external register bank.
// Accepts one command at a time (LOAD_IMM, ADD, SUB, READ), reads operands through
// the bank read ports, writes results through the bank write port and presents a
// response that is held until consumed.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   cmd_valid / cmd_ready        command handshake
//   cmd_op                       00 LOAD_IMM, 01 ADD, 10 SUB, 11 READ
//   cmd_dst, cmd_src1, cmd_src2  register addresses
//   cmd_imm                      immediate for LOAD_IMM
//   write_enable/addr/data       bank write port (one-cycle strobe)
//   reg_addr_1/2, reg_data_1/2   bank read ports (data combinational from address)
//   rsp_valid / rsp_ready        response handshake
//   rsp_data1, rsp_data2         response data
//   rsp_flag                     carry (ADD) or borrow (SUB)
module reg8_bank_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [ADDR_W-1:0] cmd_src2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic [ADDR_W-1:0] reg_addr_1,
  output logic [ADDR_W-1:0] reg_addr_2,
  input  logic [DATA_W-1:0] reg_data_1,
  input  logic [DATA_W-1:0] reg_data_2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic              rsp_flag
);

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpAdd  = 2'b01;
  localparam logic [1:0] OpSub  = 2'b10;
  localparam logic [1:0] OpRead = 2'b11;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] op1_q, op2_q;
  logic [DATA_W-1:0] add_w;
  logic              carry;
  logic              accept;

  assign accept = cmd_valid & cmd_ready;

  // Carry out of the MSB is present exactly when the truncated sum wraps below op1.
  assign add_w = op1_q + op2_q;
  assign carry = (add_w < op1_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = (cmd_op == OpLoad) ? StWrite : StRead;
      StRead:  state_d = (op_q == OpRead) ? StResp : StWrite;
      StWrite: state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // All outputs are registered; strobes are decoded from the next state so they
  // line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready    <= 1'b0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      reg_addr_1   <= '0;
      reg_addr_2   <= '0;
      rsp_valid    <= 1'b0;
      rsp_data1    <= '0;
      rsp_data2    <= '0;
      rsp_flag     <= 1'b0;
      op_q         <= OpLoad;
      op1_q        <= '0;
      op2_q        <= '0;
    end else begin
      cmd_ready    <= (state_d == StIdle);
      write_enable <= (state_d == StWrite);
      rsp_valid    <= (state_d == StResp);
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q       <= cmd_op;
            write_addr <= cmd_dst;
            reg_addr_1 <= cmd_src1;
            reg_addr_2 <= cmd_src2;
            if (cmd_op == OpLoad) write_data <= cmd_imm;
          end
        end
        StRead: begin
          op1_q <= reg_data_1;
          op2_q <= reg_data_2;
          if (op_q == OpRead) begin
            rsp_data1 <= reg_data_1;
            rsp_data2 <= reg_data_2;
            rsp_flag  <= 1'b0;
          end else if (op_q == OpAdd) begin
            write_data <= reg_data_1 + reg_data_2;
          end else begin
            write_data <= reg_data_1 - reg_data_2;
          end
        end
        StWrite: begin
          rsp_data1 <= write_data;
          rsp_data2 <= '0;
          if (op_q == OpAdd) begin
            rsp_flag <= carry;
          end else if (op_q == OpSub) begin
            rsp_flag <= (op2_q > op1_q);
          end else begin
            rsp_flag <= 1'b0;
          end
        end
        StResp: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
